// File: rtl/reg_writeback_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// reg_writeback_ctrl_pkg
//   Shared definitions for the register writeback controller.
//   - Default widths and depths for the controller and its interface.
//   - REG_ZERO / NUM_REGS describe the register file (r0 hardwired zero).
//   - wb_sel_e names the source that owns the write port in a given cycle.
//   - reg_onehot() turns a register number into a scoreboard mask. The mask
//     bit for r0 is never set, so r0 can never look busy.
// ---------------------------------------------------------------------------
package reg_writeback_ctrl_pkg;

   localparam int DATA_W_DEF        = 32;
   localparam int ADDR_W_DEF        = 5;
   localparam int LD_FIFO_DEPTH_DEF = 4;
   localparam int NUM_REGS          = 32;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_ALU  = 2'd1,
      SEL_FIFO = 2'd2,
      SEL_BYP  = 2'd3
   } wb_sel_e;

   // One-hot scoreboard mask for register r; r0 maps to an all-zero mask
   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [4:0] r);
      logic [NUM_REGS-1:0] mask_s;
      mask_s = 32'd0;
      if (r != REG_ZERO) begin
         mask_s[r] = 1'b1;
      end else begin
         mask_s = 32'd0;
      end
      return mask_s;
   endfunction

endpackage

// File: rtl/reg_writeback_ctrl_if.sv
// ---------------------------------------------------------------------------
// reg_writeback_ctrl_if
//   Bundles every signal of the writeback controller except clk/rst.
//   master : issue stage / ALU / load unit side (drives requests, sees
//            stall and the regfile write port)
//   slave  : the writeback controller itself
//   Signals:
//     iss_valid/iss_rs/iss_rt/iss_rd/iss_load  issue request, stall back
//     alu_valid/alu_rd/alu_data                single-cycle ALU result
//     ld_valid/ld_rd/ld_data                   load data return
//     L_S/Wt_addr/Wt_data                      regfile write port
//     busy_vec/pending_loads/ld_overflow       status
// ---------------------------------------------------------------------------
interface reg_writeback_ctrl_if
   import reg_writeback_ctrl_pkg::*;
#(
   parameter int DATA_W        = DATA_W_DEF,
   parameter int ADDR_W        = ADDR_W_DEF,
   parameter int LD_FIFO_DEPTH = LD_FIFO_DEPTH_DEF
) ();

   localparam int CNT_W = $clog2(LD_FIFO_DEPTH) + 1;

   logic                iss_valid;
   logic [ADDR_W-1:0]   iss_rs;
   logic [ADDR_W-1:0]   iss_rt;
   logic [ADDR_W-1:0]   iss_rd;
   logic                iss_load;
   logic                stall;

   logic                alu_valid;
   logic [ADDR_W-1:0]   alu_rd;
   logic [DATA_W-1:0]   alu_data;

   logic                ld_valid;
   logic [ADDR_W-1:0]   ld_rd;
   logic [DATA_W-1:0]   ld_data;

   logic                L_S;
   logic [ADDR_W-1:0]   Wt_addr;
   logic [DATA_W-1:0]   Wt_data;
   logic [NUM_REGS-1:0] busy_vec;
   logic [CNT_W-1:0]    pending_loads;
   logic                ld_overflow;

   modport master (
      output iss_valid, iss_rs, iss_rt, iss_rd, iss_load,
      output alu_valid, alu_rd, alu_data,
      output ld_valid, ld_rd, ld_data,
      input  stall, L_S, Wt_addr, Wt_data, busy_vec, pending_loads, ld_overflow
   );

   modport slave (
      input  iss_valid, iss_rs, iss_rt, iss_rd, iss_load,
      input  alu_valid, alu_rd, alu_data,
      input  ld_valid, ld_rd, ld_data,
      output stall, L_S, Wt_addr, Wt_data, busy_vec, pending_loads, ld_overflow
   );

endinterface

// File: rtl/reg_writeback_ctrl_ld_fifo.sv
// ---------------------------------------------------------------------------
// reg_writeback_ctrl_ld_fifo
//   Synchronous FIFO holding load returns as {rd, data}. Pointers carry one
//   extra MSB so full and empty are told apart without a counter.
//   Ports:
//     clk, rst    clock, asynchronous active-low reset (empties the FIFO)
//     push        write push_data (ignored when full unless popping)
//     push_data   entry to enqueue
//     pop         remove head (ignored when empty)
//     full/empty  occupancy flags
//     head        current head entry (valid when !empty)
// ---------------------------------------------------------------------------
module reg_writeback_ctrl_ld_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic [WIDTH-1:0] mem_r [DEPTH];
   logic             full_s;
   logic             empty_s;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign empty_s = (wr_ptr_r == rd_ptr_r);
   assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);

   // A full FIFO still accepts a push when the head leaves in the same cycle
   assign push_ok_s = push & (~full_s | pop);
   assign pop_ok_s  = pop & ~empty_s;

   assign full  = full_s;
   assign empty = empty_s;
   assign head  = mem_r[rd_ptr_r[AW-1:0]];

   // Entry storage; pure datapath, validity is tracked by the pointers
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= push_data;
      end
   end

   // Read/write pointers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= {(AW+1){1'b0}};
         rd_ptr_r <= {(AW+1){1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// ---------------------------------------------------------------------------
// reg_writeback_ctrl
//   Merges single-cycle ALU results and variable-latency load returns onto
//   the register file's single write port, and tracks outstanding loads in
//   a per-register busy scoreboard that stalls RAW/WAW hazards at issue.
//   Ports:
//     clk, rst   clock, asynchronous active-low reset
//     bus        reg_writeback_ctrl_if.slave: issue request / stall, ALU
//                result, load return, regfile write port (L_S, Wt_addr,
//                Wt_data, registered), busy_vec, pending_loads, ld_overflow
//   Write-port priority: ALU > queued load (FIFO head) > load bypass.
// ---------------------------------------------------------------------------
module reg_writeback_ctrl
   import reg_writeback_ctrl_pkg::*;
#(
   parameter int DATA_W        = DATA_W_DEF,
   parameter int ADDR_W        = ADDR_W_DEF,
   parameter int LD_FIFO_DEPTH = LD_FIFO_DEPTH_DEF
) (
   input  logic               clk,
   input  logic               rst,
   reg_writeback_ctrl_if.slave bus
);

   localparam int CNT_W  = $clog2(LD_FIFO_DEPTH) + 1;
   localparam int FIFO_W = ADDR_W + DATA_W;

   logic [NUM_REGS-1:0] busy_r;
   logic [CNT_W-1:0]    pending_r;
   logic                l_s_r;
   logic [ADDR_W-1:0]   wt_addr_r;
   logic [DATA_W-1:0]   wt_data_r;
   logic                wb_is_ld_r;
   logic                ld_overflow_r;

   logic                stall_s;
   logic                accept_s;
   logic                ld_issue_s;
   logic                ld_commit_s;
   logic [NUM_REGS-1:0] set_mask_s;
   logic [NUM_REGS-1:0] clr_mask_s;

   wb_sel_e             sel_s;
   logic                sel_valid_s;
   logic [ADDR_W-1:0]   sel_rd_s;
   logic [DATA_W-1:0]   sel_data_s;
   logic                sel_is_ld_s;
   logic                fifo_push_s;
   logic                fifo_pop_s;
   logic                fifo_full_s;
   logic                fifo_empty_s;
   logic [FIFO_W-1:0]   fifo_head_s;

   // ---------------- issue hazard check ----------------
   assign stall_s = bus.iss_valid &
                    (busy_r[bus.iss_rs] | busy_r[bus.iss_rt] | busy_r[bus.iss_rd] |
                     (bus.iss_load & (pending_r == CNT_W'(LD_FIFO_DEPTH))));
   assign accept_s   = bus.iss_valid & ~stall_s;
   assign ld_issue_s = accept_s & bus.iss_load;

   // A load commit is counted whenever a load owned the output register,
   // even a dropped r0 load that never raised L_S.
   assign ld_commit_s = wb_is_ld_r;

   assign set_mask_s = ld_issue_s ? reg_onehot(bus.iss_rd) : 32'd0;
   assign clr_mask_s = (l_s_r & wb_is_ld_r) ? reg_onehot(wt_addr_r) : 32'd0;

   // ---------------- load-return FIFO ----------------
   reg_writeback_ctrl_ld_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (LD_FIFO_DEPTH)
   ) u_wb_ld_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push_s),
      .push_data ({bus.ld_rd, bus.ld_data}),
      .pop       (fifo_pop_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .head      (fifo_head_s)
   );

   // Pick the write-port owner; a returning load not bypassed goes into the FIFO
   always_comb begin
      sel_s       = SEL_NONE;
      fifo_push_s = 1'b0;
      fifo_pop_s  = 1'b0;
      if (bus.alu_valid) begin
         sel_s       = SEL_ALU;
         fifo_push_s = bus.ld_valid;
      end else if (!fifo_empty_s) begin
         sel_s       = SEL_FIFO;
         fifo_pop_s  = 1'b1;
         fifo_push_s = bus.ld_valid;
      end else if (bus.ld_valid) begin
         sel_s       = SEL_BYP;
      end else begin
         sel_s       = SEL_NONE;
      end
   end

   // Write-port data mux driven by the selected owner
   always_comb begin
      sel_valid_s = 1'b0;
      sel_rd_s    = {ADDR_W{1'b0}};
      sel_data_s  = {DATA_W{1'b0}};
      sel_is_ld_s = 1'b0;
      case (sel_s)
         SEL_ALU: begin
            sel_valid_s = 1'b1;
            sel_rd_s    = bus.alu_rd;
            sel_data_s  = bus.alu_data;
         end
         SEL_FIFO: begin
            sel_valid_s = 1'b1;
            sel_rd_s    = fifo_head_s[FIFO_W-1:DATA_W];
            sel_data_s  = fifo_head_s[DATA_W-1:0];
            sel_is_ld_s = 1'b1;
         end
         SEL_BYP: begin
            sel_valid_s = 1'b1;
            sel_rd_s    = bus.ld_rd;
            sel_data_s  = bus.ld_data;
            sel_is_ld_s = 1'b1;
         end
         default: begin
            sel_valid_s = 1'b0;
            sel_is_ld_s = 1'b0;
         end
      endcase
   end

   // Regfile write-port registers; address/data hold when nothing is written
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         l_s_r      <= 1'b0;
         wt_addr_r  <= {ADDR_W{1'b0}};
         wt_data_r  <= {DATA_W{1'b0}};
         wb_is_ld_r <= 1'b0;
      end else if (sel_valid_s) begin
         l_s_r      <= (sel_rd_s != ADDR_W'(REG_ZERO));
         wt_addr_r  <= sel_rd_s;
         wt_data_r  <= sel_data_s;
         wb_is_ld_r <= sel_is_ld_s;
      end else begin
         l_s_r      <= 1'b0;
         wb_is_ld_r <= 1'b0;
      end
   end

   // Busy scoreboard; a new load issue to r beats the commit clearing r
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_r <= 32'd0;
      end else begin
         busy_r <= (busy_r & ~clr_mask_s) | set_mask_s;
      end
   end

   // Outstanding-load counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending_r <= {CNT_W{1'b0}};
      end else begin
         case ({ld_issue_s, ld_commit_s})
            2'b10:   pending_r <= pending_r + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   pending_r <= pending_r - {{(CNT_W-1){1'b0}}, 1'b1};
            default: pending_r <= pending_r;
         endcase
      end
   end

   // Sticky overflow: a load return that found the FIFO full with no pop
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ld_overflow_r <= 1'b0;
      end else if (fifo_push_s & fifo_full_s & ~fifo_pop_s) begin
         ld_overflow_r <= 1'b1;
      end else begin
         ld_overflow_r <= ld_overflow_r;
      end
   end

   assign bus.stall         = stall_s;
   assign bus.L_S           = l_s_r;
   assign bus.Wt_addr       = wt_addr_r;
   assign bus.Wt_data       = wt_data_r;
   assign bus.busy_vec      = busy_r;
   assign bus.pending_loads = pending_r;
   assign bus.ld_overflow   = ld_overflow_r;

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// ---------------------------------------------------------------------------
// tb_reg_writeback_ctrl
//   Directed bench for reg_writeback_ctrl. Expected regfile writes are queued
//   as {addr, data} when the stimulus is driven and popped by a negedge
//   monitor whenever L_S is high. Status outputs are checked directly.
// ---------------------------------------------------------------------------
module tb_reg_writeback_ctrl;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 4;

   logic clk;
   logic rst;

   int pass_cnt  = 0;
   int fail_cnt  = 0;
   int total_cnt = 0;

   logic [ADDR_W+DATA_W-1:0] exp_q [$];

   reg_writeback_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LD_FIFO_DEPTH(DEPTH)) bus ();

   reg_writeback_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LD_FIFO_DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      exp_q.push_back({a, d});
   endtask

   // Scoreboard monitor: every regfile write must match the oldest expectation
   always @(negedge clk) begin
      if (rst && bus.L_S) begin
         chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            logic [ADDR_W+DATA_W-1:0] e;
            e = exp_q.pop_front();
            chk("wb_addr", 64'(bus.Wt_addr), 64'(e[ADDR_W+DATA_W-1:DATA_W]));
            chk("wb_data", 64'(bus.Wt_data), 64'(e[DATA_W-1:0]));
         end
      end
   end

   initial begin
      rst           = 1'b0;
      bus.iss_valid = 1'b0;
      bus.iss_rs    = 5'd0;
      bus.iss_rt    = 5'd0;
      bus.iss_rd    = 5'd0;
      bus.iss_load  = 1'b0;
      bus.alu_valid = 1'b0;
      bus.alu_rd    = 5'd0;
      bus.alu_data  = 32'd0;
      bus.ld_valid  = 1'b0;
      bus.ld_rd     = 5'd0;
      bus.ld_data   = 32'd0;

      // ---- reset state ----
      #3;
      chk("rst_L_S",     64'(bus.L_S),           64'd0);
      chk("rst_addr",    64'(bus.Wt_addr),       64'd0);
      chk("rst_data",    64'(bus.Wt_data),       64'd0);
      chk("rst_busy",    64'(bus.busy_vec),      64'd0);
      chk("rst_pending", 64'(bus.pending_loads), 64'd0);
      chk("rst_ovf",     64'(bus.ld_overflow),   64'd0);
      chk("rst_stall",   64'(bus.stall),         64'd0);
      tick();
      tick();
      rst = 1'b1;

      // ---- ALU path ----
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'd5;
      bus.alu_data  = 32'h0000_1234;
      push_exp(5'd5, 32'h0000_1234);
      tick();
      bus.alu_valid = 1'b0;
      chk("alu_L_S",  64'(bus.L_S),     64'd1);
      chk("alu_addr", 64'(bus.Wt_addr), 64'd5);
      chk("alu_data", 64'(bus.Wt_data), 64'h1234);
      tick();
      chk("idle_L_S",  64'(bus.L_S),     64'd0);
      chk("idle_addr", 64'(bus.Wt_addr), 64'd5);
      chk("idle_data", 64'(bus.Wt_data), 64'h1234);

      // ---- load RAW ----
      bus.iss_valid = 1'b1;
      bus.iss_load  = 1'b1;
      bus.iss_rd    = 5'd7;
      #1;
      chk("raw_issue_stall", 64'(bus.stall), 64'd0);
      tick();
      bus.iss_load = 1'b0;
      bus.iss_rd   = 5'd0;
      bus.iss_rs   = 5'd7;
      chk("raw_busy",    64'(bus.busy_vec),      64'h80);
      chk("raw_pending", 64'(bus.pending_loads), 64'd1);
      #1;
      chk("raw_stall0", 64'(bus.stall), 64'd1);
      tick();
      chk("raw_stall1", 64'(bus.stall), 64'd1);
      tick();
      bus.ld_valid = 1'b1;
      bus.ld_rd    = 5'd7;
      bus.ld_data  = 32'h0000_CAFE;
      push_exp(5'd7, 32'h0000_CAFE);
      #1;
      chk("raw_stall2", 64'(bus.stall), 64'd1);
      tick();
      bus.ld_valid = 1'b0;
      chk("raw_ld_L_S",  64'(bus.L_S),     64'd1);
      chk("raw_ld_addr", 64'(bus.Wt_addr), 64'd7);
      chk("raw_ld_data", 64'(bus.Wt_data), 64'hCAFE);
      chk("raw_stall3",  64'(bus.stall),   64'd1);
      tick();
      chk("raw_stall_rel", 64'(bus.stall),         64'd0);
      chk("raw_busy_clr",  64'(bus.busy_vec),      64'd0);
      chk("raw_pend_clr",  64'(bus.pending_loads), 64'd0);
      bus.iss_valid = 1'b0;
      bus.iss_rs    = 5'd0;

      // ---- contention: ALU beats load ----
      bus.iss_valid = 1'b1;
      bus.iss_load  = 1'b1;
      bus.iss_rd    = 5'd9;
      tick();
      bus.iss_valid = 1'b0;
      bus.iss_load  = 1'b0;
      bus.iss_rd    = 5'd0;
      chk("cont_busy", 64'(bus.busy_vec), 64'h200);
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'd3;
      bus.alu_data  = 32'h0000_0033;
      bus.ld_valid  = 1'b1;
      bus.ld_rd     = 5'd9;
      bus.ld_data   = 32'h0000_0099;
      push_exp(5'd3, 32'h0000_0033);
      push_exp(5'd9, 32'h0000_0099);
      tick();
      bus.alu_valid = 1'b0;
      bus.ld_valid  = 1'b0;
      chk("cont_first",  64'(bus.Wt_addr), 64'd3);
      tick();
      chk("cont_second", 64'(bus.Wt_addr), 64'd9);
      chk("cont_L_S",    64'(bus.L_S),     64'd1);
      tick();
      chk("cont_pending", 64'(bus.pending_loads), 64'd0);
      chk("cont_busy_clr", 64'(bus.busy_vec),     64'd0);

      // ---- fill: 4 outstanding loads, queue behind ALU, drain in order ----
      for (int i = 0; i < 4; i++) begin
         bus.iss_valid = 1'b1;
         bus.iss_load  = 1'b1;
         bus.iss_rd    = 5'(10 + i);
         tick();
      end
      chk("fill_pending4", 64'(bus.pending_loads), 64'd4);
      chk("fill_busy",     64'(bus.busy_vec),      64'h3C00);
      bus.iss_rd = 5'd14;
      #1;
      chk("fill_stall5", 64'(bus.stall), 64'd1);
      bus.iss_valid = 1'b0;
      bus.iss_load  = 1'b0;
      bus.iss_rd    = 5'd0;
      for (int i = 0; i < 4; i++) begin
         bus.alu_valid = 1'b1;
         bus.alu_rd    = 5'(20 + i);
         bus.alu_data  = 32'h100 + 32'(i);
         bus.ld_valid  = 1'b1;
         bus.ld_rd     = 5'(10 + i);
         bus.ld_data   = 32'hA0 + 32'(i);
         push_exp(5'(20 + i), 32'h100 + 32'(i));
         tick();
      end
      bus.alu_valid = 1'b0;
      bus.ld_valid  = 1'b0;
      chk("fill_pend_hold", 64'(bus.pending_loads), 64'd4);
      chk("fill_no_ovf",    64'(bus.ld_overflow),   64'd0);
      for (int i = 0; i < 4; i++) begin
         push_exp(5'(10 + i), 32'hA0 + 32'(i));
      end
      repeat (5) tick();
      chk("fill_pending0", 64'(bus.pending_loads), 64'd0);
      chk("fill_busy_clr", 64'(bus.busy_vec),      64'd0);

      // ---- r0 handling ----
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'd0;
      bus.alu_data  = 32'h55;
      tick();
      bus.alu_valid = 1'b0;
      chk("r0_alu_L_S", 64'(bus.L_S), 64'd0);
      bus.iss_valid = 1'b1;
      bus.iss_load  = 1'b1;
      bus.iss_rd    = 5'd0;
      #1;
      chk("r0_iss_stall", 64'(bus.stall), 64'd0);
      tick();
      bus.iss_valid = 1'b0;
      bus.iss_load  = 1'b0;
      chk("r0_pending1", 64'(bus.pending_loads), 64'd1);
      chk("r0_busy",     64'(bus.busy_vec),      64'd0);
      bus.ld_valid = 1'b1;
      bus.ld_rd    = 5'd0;
      bus.ld_data  = 32'h77;
      tick();
      bus.ld_valid = 1'b0;
      chk("r0_ld_L_S", 64'(bus.L_S), 64'd0);
      tick();
      chk("r0_pending0", 64'(bus.pending_loads), 64'd0);
      chk("r0_busy0",    64'(bus.busy_vec),      64'd0);

      // ---- reset mid-traffic ----
      bus.iss_valid = 1'b1;
      bus.iss_load  = 1'b1;
      bus.iss_rd    = 5'd15;
      tick();
      bus.iss_rd = 5'd16;
      tick();
      bus.iss_valid = 1'b0;
      bus.iss_load  = 1'b0;
      bus.iss_rd    = 5'd0;
      chk("mid_pending2", 64'(bus.pending_loads), 64'd2);
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'd1;
      bus.alu_data  = 32'h11;
      bus.ld_valid  = 1'b1;
      bus.ld_rd     = 5'd15;
      bus.ld_data   = 32'hF5;
      tick();
      bus.alu_valid = 1'b0;
      bus.ld_valid  = 1'b0;
      rst = 1'b0;
      #1;
      chk("mid_rst_L_S",  64'(bus.L_S),           64'd0);
      chk("mid_rst_addr", 64'(bus.Wt_addr),       64'd0);
      chk("mid_rst_data", 64'(bus.Wt_data),       64'd0);
      chk("mid_rst_busy", 64'(bus.busy_vec),      64'd0);
      chk("mid_rst_pend", 64'(bus.pending_loads), 64'd0);
      tick();
      rst = 1'b1;
      tick();
      chk("mid_fifo_empty0", 64'(bus.L_S), 64'd0);
      tick();
      chk("mid_fifo_empty1", 64'(bus.L_S), 64'd0);
      chk("mid_pend_after",  64'(bus.pending_loads), 64'd0);

      chk("sb_drained", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
